// File: rtl/lockout_pkg.sv
// Shared types and limits for the escalating lockout timer.
package lockout_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [6:0] MAX_SECONDS = 7'd99;
  localparam logic [1:0] LEVEL_MAX   = 2'd3;
endpackage

// File: rtl/lockout_timer_tick_gen.sv
// One-second prescaler: one-cycle tick every CLK_HZ cycles while run is high.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic run,
  output logic tick
);
  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                   cnt <= '0;
    else if (!run || cnt == TERM)   cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

  assign tick = run && (cnt == TERM);
endmodule

// File: rtl/lockout_timer.sv
// Escalating lockout: converts verify's trials-exhausted level into a timed,
// doubling lockout and drives the shared enable line plus BCD countdown.
module lockout_timer
  import lockout_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int LOCK_SECONDS = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       lock_req,
  input  logic       pass_pulse,
  input  logic       clear_key,
  output logic       enable,
  output logic       locked,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] lock_level
);
  state_t     state, state_d;
  logic [6:0] remaining, remaining_d;
  logic [1:0] level_d, level_base, level_inc;
  logic [9:0] shifted;
  logic [6:0] load_val;
  logic       req_s, req_q, req_rise, tick;

  function automatic logic [7:0] to_bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .run      (state == LOCKED),
    .tick     (tick)
  );

  // lock_req is sampled first, then compared with its previous sample, so
  // entry lands one edge after the first high sample.
  assign req_rise = req_s & ~req_q;

  // A pass in the same cycle as lock entry restarts escalation from zero.
  assign level_base = pass_pulse ? 2'd0 : lock_level;
  assign level_inc  = (level_base == LEVEL_MAX) ? LEVEL_MAX : level_base + 2'd1;
  // Wide enough for 99 << 3, so the cap always sees the true product.
  assign shifted    = 10'(LOCK_SECONDS) << level_base;
  assign load_val   = (shifted > {3'b000, MAX_SECONDS}) ? MAX_SECONDS : shifted[6:0];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= '0;
      lock_level <= '0;
      req_s      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state      <= state_d;
      remaining  <= remaining_d;
      lock_level <= level_d;
      req_s      <= lock_req;
      req_q      <= req_s;
    end
  end

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    level_d     = lock_level;
    case (state)
      IDLE: begin
        if (req_rise) begin
          state_d     = LOCKED;
          remaining_d = load_val;
          level_d     = level_inc;
        end else if (pass_pulse) begin
          level_d = 2'd0;
        end
      end
      LOCKED: begin
        if (clear_key) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (tick) begin
          if (remaining <= 7'd1) begin
            state_d     = IDLE;
            remaining_d = '0;
          end else begin
            remaining_d = remaining - 7'd1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  assign enable             = (state == IDLE);
  assign locked             = ~enable;
  assign {sec_tens, sec_ones} = to_bcd(remaining);
endmodule
